// File: rtl/block_copier_if.sv
// block_copier_if: register-window responder signals plus system-bus initiator signals; master = CPU/bus side, slave = copier side
interface block_copier_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [15:0] low_address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        bus_request;
  logic        bus_grant;
  logic [29:0] m_address;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  logic [3:0]  m_data_strobes;
  logic        m_read;
  logic        m_write;
  modport master (
    output cs, read, write, low_address, data_in, bus_grant, m_data_in,
    input  data_out, bus_request, m_address, m_data_out, m_data_strobes, m_read, m_write
  );
  modport slave (
    input  cs, read, write, low_address, data_in, bus_grant, m_data_in,
    output data_out, bus_request, m_address, m_data_out, m_data_strobes, m_read, m_write
  );
endinterface

// File: rtl/block_copier.sv
// block_copier: word copy engine; ports clock, n_reset, bus (register responder + bus initiator), busy, irq (= done)
module block_copier (
  input  logic          clock,
  input  logic          n_reset,
  block_copier_if.slave bus,
  output logic          busy,
  output logic          irq
);
  typedef enum logic [2:0] {IDLE, REQUEST, READ, CAPTURE, WRITE} state_t;
  state_t state, state_n;
  logic [29:0] src, dst;
  logic [15:0] count;
  logic [31:0] buffer, rdata;
  logic done, aborted, abort_pending;
  logic wr, ctrl, start, abort, stop, finish, unused_ok;
  assign wr = bus.cs & bus.write;
  assign ctrl = wr & (bus.low_address[3:2] == 2'd3);
  assign start = ctrl & bus.data_in[0] & (state == IDLE);
  assign abort = ctrl & bus.data_in[2];
  assign stop = abort_pending | abort;
  assign finish = (state == WRITE) & ((count == 16'd1) | stop);
  assign busy = state != IDLE;
  assign irq = done;
  assign unused_ok = ^{bus.low_address[15:4], bus.low_address[1:0]};
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && count != 16'd0) state_n = REQUEST;
      REQUEST: if (bus.bus_grant) state_n = READ;
      READ:    state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = finish ? IDLE : READ;
      default: state_n = IDLE;
    endcase
    bus.bus_request = busy;
    bus.m_read = state == READ;
    bus.m_write = state == WRITE;
    bus.m_address = state == READ ? src : state == WRITE ? dst : 30'd0;
    bus.m_data_out = state == WRITE ? buffer : 32'd0;
    bus.m_data_strobes = {4{state == WRITE}};
  end
  always_comb begin
    rdata = bus.low_address[3:2] == 2'd0 ? {src, 2'b00}
          : bus.low_address[3:2] == 2'd1 ? {dst, 2'b00}
          : bus.low_address[3:2] == 2'd2 ? {16'd0, count}
          : {29'd0, aborted, done, busy};
  end
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      src <= '0;
      dst <= '0;
      count <= '0;
      buffer <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      abort_pending <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (wr && !busy && bus.low_address[3:2] == 2'd0) src <= bus.data_in[31:2];
      if (wr && !busy && bus.low_address[3:2] == 2'd1) dst <= bus.data_in[31:2];
      if (wr && !busy && bus.low_address[3:2] == 2'd2) count <= bus.data_in[15:0];
      if (state == CAPTURE) buffer <= bus.m_data_in;
      if (state == WRITE) begin
        src <= src + 30'd1;
        dst <= dst + 30'd1;
        count <= count - 16'd1;
      end
      if (start) begin
        done <= count == 16'd0;
        aborted <= 1'b0;
      end else if (finish) begin
        done <= 1'b1;
        aborted <= stop;
      end else if (ctrl && bus.data_in[1]) done <= 1'b0;
      abort_pending <= busy & ~finish & stop;
      if (bus.cs && bus.read) bus.data_out <= rdata;
    end
endmodule

// File: tb/tb_block_copier.sv
// tb_block_copier: randomized self-checking bench for block_copier against a word-level copy model
module tb_block_copier;
  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic busy, irq;
  block_copier_if bus();
  block_copier dut (.clock(clock), .n_reset(n_reset), .bus(bus), .busy(busy), .irq(irq));
  always #5 clock = ~clock;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cycles = 0;
  int req_cycles = 0;
  int first_busy = 0;
  int bad = 0;
  logic prev_busy = 1'b0;
  logic [29:0] rd_addr[$];
  int rd_cyc[$];
  logic [61:0] wlog[$];
  logic [61:0] exp_q[$];
  logic [31:0] mem [logic [29:0]];
  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : ({a[15:0], ~a[15:0]} ^ 32'hA5C3_0F1E);
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask
  always @(negedge clock) begin
    cyc++;
    if (busy) busy_cycles++;
    if (bus.bus_request) req_cycles++;
    if (busy && !prev_busy) first_busy = cyc;
    prev_busy = busy;
    if (bus.m_read) begin
      rd_addr.push_back(bus.m_address);
      rd_cyc.push_back(cyc);
    end
    if (bus.m_write) begin
      wlog.push_back({bus.m_address, bus.m_data_out});
      mem[bus.m_address] = bus.m_data_out;
    end
    if (bus.m_data_strobes !== {4{bus.m_write}}) bad++;
    if (bus.bus_request !== busy) bad++;
    if (bus.m_read && bus.m_write) bad++;
  end
  always @(posedge clock) begin : mem_port
    logic pr;
    logic [29:0] pa;
    pr = bus.m_read;
    pa = bus.m_address;
    #1 bus.m_data_in = pr ? mem_rd(pa) : $urandom;
  end
  task automatic build_model(input logic [29:0] s, input logic [29:0] d, input int n);
    logic [31:0] ovl [logic [29:0]];
    logic [29:0] as, ad;
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      as = s + 30'(i);
      ad = d + 30'(i);
      v = ovl.exists(as) ? ovl[as] : mem_rd(as);
      ovl[ad] = v;
      exp_q.push_back({ad, v});
    end
  endtask
  task automatic clear_logs();
    rd_addr.delete();
    rd_cyc.delete();
    wlog.delete();
    busy_cycles = 0;
    req_cycles = 0;
    bad = 0;
  endtask
  task automatic reg_write(input logic [1:0] idx, input logic [31:0] d);
    @(negedge clock);
    bus.cs = 1'b1;
    bus.write = 1'b1;
    bus.low_address = {12'($urandom), idx, 2'($urandom)};
    bus.data_in = d;
    @(negedge clock);
    bus.cs = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic reg_read(input logic [1:0] idx, output logic [31:0] d);
    @(negedge clock);
    bus.cs = 1'b1;
    bus.read = 1'b1;
    bus.low_address = {12'($urandom), idx, 2'($urandom)};
    @(negedge clock);
    bus.cs = 1'b0;
    bus.read = 1'b0;
    d = bus.data_out;
  endtask
  task automatic wait_idle(input string tag, input int limit);
    int i = 0;
    while (busy && i < limit) begin
      @(negedge clock);
      i++;
    end
    check({tag, "_timeout"}, busy, 0);
  endtask
  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwr"}, wlog.size(), n);
    foreach (wlog[i]) check({tag, "_wr"}, wlog[i], i < exp_q.size() ? exp_q[i] : 62'h0);
  endtask
  task automatic do_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n, input int g);
    logic [31:0] v;
    build_model(s[31:2], d[31:2], n);
    clear_logs();
    bus.bus_grant = (g == 0);
    reg_write(2'd0, s);
    reg_write(2'd1, d);
    reg_write(2'd2, 32'(n));
    reg_write(2'd3, 32'h3);
    check({tag, "_irq_clr"}, irq, 0);
    if (g > 0) begin
      repeat (g) @(negedge clock);
      check({tag, "_idle_wait"}, rd_addr.size() + wlog.size(), 0);
      bus.bus_grant = 1'b1;
    end
    wait_idle(tag, 1000);
    check({tag, "_busy_cyc"}, busy_cycles, 3 * n + 1 + g);
    check({tag, "_first_rd"}, rd_cyc.size() > 0 ? rd_cyc[0] - first_busy : -1, 1 + g);
    check({tag, "_nrd"}, rd_addr.size(), n);
    foreach (rd_addr[i]) check({tag, "_rd"}, rd_addr[i], s[31:2] + 30'(i));
    check_writes(tag, n);
    reg_read(2'd2, v);
    check({tag, "_count"}, v, 0);
    reg_read(2'd0, v);
    check({tag, "_src"}, v, {s[31:2], 2'b00} + 32'(4 * n));
    reg_read(2'd1, v);
    check({tag, "_dst"}, v, {d[31:2], 2'b00} + 32'(4 * n));
    reg_read(2'd3, v);
    check({tag, "_status"}, v, 2);
    check({tag, "_irq"}, irq, 1);
    check({tag, "_bad"}, bad, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    logic [29:0] wrap_rd [3];
    int c;
    wrap_rd = '{30'h3FFF_FFFE, 30'h3FFF_FFFF, 30'h0};
    bus.cs = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.low_address = '0;
    bus.data_in = '0;
    bus.bus_grant = 1'b1;
    bus.m_data_in = '0;
    repeat (3) @(negedge clock);
    check("rst_out_a", {busy, irq, bus.bus_request, bus.m_read, bus.m_write, bus.m_data_strobes, bus.m_address}, 0);
    check("rst_out_b", {bus.m_data_out, bus.data_out}, 0);
    n_reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), v);
      check("rst_reg", v, 0);
    end
    do_copy("basic", 32'h0000_0100, 32'h0100_0000, 4, 0);
    check("basic_addr0", wlog.size() > 0 ? wlog[0][61:32] : 30'h0, 30'h0040_0000);
    check("basic_addr3", wlog.size() > 3 ? wlog[3][61:32] : 30'h0, 30'h0040_0003);
    reg_write(2'd3, 32'h2);
    reg_read(2'd3, v);
    check("clr_status", v, 0);
    check("clr_irq", irq, 0);
    clear_logs();
    reg_write(2'd2, 32'h0);
    reg_write(2'd3, 32'h1);
    repeat (4) @(negedge clock);
    check("zero_activity", rd_addr.size() + wlog.size() + req_cycles + busy_cycles, 0);
    reg_read(2'd3, v);
    check("zero_status", v, 2);
    check("zero_irq", irq, 1);
    do_copy("gnt5", 32'h0000_2000, 32'h0000_4000, 3, 5);
    build_model(30'h0000_0400, 30'h0000_0800, 10);
    clear_logs();
    bus.bus_grant = 1'b1;
    reg_write(2'd0, 32'h0000_1000);
    reg_write(2'd1, 32'h0000_2000);
    reg_write(2'd2, 32'd10);
    reg_write(2'd3, 32'h1);
    c = 0;
    while (wlog.size() < 3 && c < 200) begin
      @(negedge clock);
      c++;
    end
    check("abort_reach", wlog.size() >= 3, 1);
    reg_write(2'd3, 32'h4);
    wait_idle("abort", 200);
    reg_read(2'd2, v);
    check("abort_count", v == 6 || v == 7, 1);
    check_writes("abort", 10 - int'(v));
    reg_read(2'd3, v);
    check("abort_status", v, 6);
    build_model(30'h0000_0C00, 30'h0000_1400, 5);
    clear_logs();
    bus.bus_grant = 1'b0;
    reg_write(2'd0, 32'h0000_3000);
    reg_write(2'd1, 32'h0000_5000);
    reg_write(2'd2, 32'd5);
    reg_write(2'd3, 32'h1);
    reg_write(2'd3, 32'h4);
    check("abrq_no_bus", rd_addr.size() + wlog.size(), 0);
    bus.bus_grant = 1'b1;
    wait_idle("abrq", 200);
    reg_read(2'd2, v);
    check("abrq_min1", wlog.size() >= 1, 1);
    check("abrq_count", v, 5 - wlog.size());
    check_writes("abrq", wlog.size());
    reg_read(2'd3, v);
    check("abrq_status", v, 6);
    build_model(30'h3FFF_FFFE, 30'h0000_0800, 3);
    clear_logs();
    reg_write(2'd0, 32'hFFFF_FFF8);
    reg_write(2'd1, 32'h0000_2000);
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'h1);
    reg_write(2'd0, 32'h1234_5678);
    wait_idle("wrap", 200);
    check("wrap_nrd", rd_addr.size(), 3);
    foreach (rd_addr[i]) check("wrap_rd", rd_addr[i], i < 3 ? wrap_rd[i] : 30'h0);
    check_writes("wrap", 3);
    reg_read(2'd0, v);
    check("wrap_src", v, 32'h0000_0004);
    reg_read(2'd1, v);
    check("wrap_dst", v, 32'h0000_200C);
    clear_logs();
    reg_write(2'd0, 32'h0000_6000);
    reg_write(2'd1, 32'h0000_7000);
    reg_write(2'd2, 32'd8);
    reg_write(2'd3, 32'h1);
    c = 0;
    while (wlog.size() < 2 && c < 200) begin
      @(negedge clock);
      c++;
    end
    check("rstmid_reach", wlog.size() >= 2, 1);
    @(negedge clock);
    #2 n_reset = 1'b0;
    #1;
    check("rstmid_out_a", {busy, irq, bus.bus_request, bus.m_read, bus.m_write, bus.m_data_strobes, bus.m_address}, 0);
    check("rstmid_out_b", {bus.m_data_out, bus.data_out}, 0);
    @(negedge clock);
    n_reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), v);
      check("rstmid_reg", v, 0);
    end
    do_copy("post_rst", 32'h0000_6000, 32'h0000_9000, 4, 1);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] s, d;
      s = $urandom;
      d = (k % 3 == 2) ? s + 32'(4 * $urandom_range(1, 3)) : $urandom;
      do_copy("rnd", s, d, int'($urandom_range(1, 12)), int'($urandom_range(0, 4)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/block_copier.md
# block_copier

Memory-to-memory word copy engine for the maxicore32 system bus. It has two bus ports. The CPU programs it through a register window, where it is a responder alongside memory, map and display. It then takes the bus as a second initiator and copies a block of 32-bit words, for example from RAM into the tile map RAM. It requests the bus from an external arbiter, performs read/write pairs, and reports completion through a status register and a level interrupt.

## Interface
- No parameters; count width fixed at 16 bits, addresses are 30-bit word addresses.
- clock  in  1  system (cpu) clock; all state updates on posedge
- n_reset  in  1  asynchronous, active-low reset
- cs  in  1  register window select from address decoder
- read  in  1  responder read strobe
- write  in  1  responder write strobe
- low_address  in  16  responder byte address; bits [3:2] select register, others ignored
- data_in  in  32  responder write data
- data_out  out  32  responder read data, registered
- bus_request  out  1  request bus ownership from arbiter
- bus_grant  in  1  ownership granted; arbiter never revokes while bus_request=1
- m_address  out  30  initiator word address [31:2]
- m_data_in  in  32  initiator read data, valid the cycle after m_read
- m_data_out  out  32  initiator write data
- m_data_strobes  out  4  byte strobes; 4'b1111 during writes, 4'b0000 otherwise
- m_read  out  1  initiator read strobe
- m_write  out  1  initiator write strobe
- busy  out  1  copy in progress
- irq  out  1  equals status.done

## Operation
- Registers (low_address[3:2]):
  - 0 SRC: source byte address; bits [1:0] read as 0.
  - 1 DST: destination byte address; bits [1:0] read as 0.
  - 2 COUNT: words remaining, [15:0]; [31:16] read 0.
  - 3 CTRL/STATUS:
    - write bit0=1 starts a copy; bit1=1 clears done; bit2=1 requests abort.
    - read bit0=busy, bit1=done, bit2=aborted.
- While busy, writes to SRC/DST/COUNT and start are ignored. Done-clear and abort are honoured.
- FSM states IDLE, REQUEST, READ, CAPTURE, WRITE.
  - IDLE: a start write moves to REQUEST and clears aborted. If COUNT=0 at start, the FSM stays in IDLE and sets done the same edge; there is no bus activity.
  - REQUEST: bus_request=1. bus_grant sampled high moves to READ.
  - READ: m_read=1, m_address=SRC[31:2].
  - CAPTURE: latch m_data_in into the word buffer.
  - WRITE: m_write=1, m_address=DST[31:2], m_data_out=buffer, strobes 1111.
  - Leaving WRITE: SRC+=4, DST+=4, COUNT-=1. If the new COUNT=0 or an abort is pending, go to IDLE, set done, and set aborted if an abort was pending. Otherwise go to READ.
- bus_request is held from REQUEST through the final WRITE and drops in IDLE.
- Abort is latched and acts only at a word boundary. A word is never half-copied. COUNT then shows the words not copied.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC+4 wraps to 0x00000000.
- Responder read: data_out is updated on the edge where cs&read is sampled and holds otherwise. Reads have no side effects.
- Reset values: all registers 0, FSM IDLE, data_out=0, bus_request=0, m_read=m_write=0, m_address=0, m_data_out=0, strobes=0, busy=0, irq=0.
- Reset asserted mid-copy aborts immediately to the reset state. Memory may hold a partial block.

## Timing
- Start written at edge N: busy=1 and bus_request=1 from N+1.
- With bus_grant already high, READ occurs at N+2. Each word takes 3 cycles (READ, CAPTURE, WRITE).
- The last WRITE is in cycle N+1+3n. done/irq go high and busy and bus_request go low at the following edge.
- A grant delay of g cycles adds exactly g cycles in REQUEST.
- Done-clear and start written in the same access: start wins and done is cleared.
- If done-clear coincides with the final WRITE edge, done is set. Completion wins.
- Abort written during REQUEST: at least one word is copied before stopping.

## Test plan
- SRC=0x00000100, DST=0x01000000, COUNT=4, grant tied high: four writes of the words at 0x100..0x10C to map addresses 0x01000000..0x0100000C. COUNT reads 0, done=1, irq=1, busy high for exactly 13 cycles.
- COUNT=0, start: no m_read/m_write ever; done=1 on the next read; bus_request stays 0.
- bus_grant held low for 5 cycles after the request: READ begins exactly 5 cycles later than in the ungranted-free case; outputs stay idle meanwhile.
- COUNT=10, abort written after the 3rd write: copy stops after the 3rd or 4th word. COUNT reads 7 or 6 respectively; status reads done=1, aborted=1; no partial word is written.
- SRC=0xFFFFFFF8, COUNT=3: reads 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000 on m_address. Writes to SRC while busy leave it unchanged.
- n_reset pulsed low mid-copy: all outputs return to 0 asynchronously, registers read 0, and a subsequent start behaves normally.
